// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC register, one-deep in-flight tracking and a
// small FIFO of {instr, pc} pairs toward decode, with credit-based request gating.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [2:0]  occupancy
);

    typedef logic [1:0] ptr_t;

    localparam logic [2:0] DEPTH3 = 3'(BUF_DEPTH);

    // Storage is sized for the largest legal depth; pointers wrap at BUF_DEPTH.
    logic [31:0] instr_mem_q [4];
    logic [31:0] pc_mem_q    [4];

    logic [31:0] pc_q, pc_d;
    logic [31:0] issued_pc_q, issued_pc_d;
    logic        inflight_q, inflight_d;
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    logic [2:0]  occupancy_q, occupancy_d;

    logic        pop;
    logic        push;
    logic [2:0]  used_credit;
    logic        unused_bits;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign unused_bits = ^redirect_pc[1:0];

    assign instr_valid = rst & (occupancy_q != 3'd0);
    assign instr       = instr_mem_q[head_q];
    assign instr_pc    = pc_mem_q[head_q];
    assign occupancy   = occupancy_q;
    assign imem_addr   = pc_q;

    assign pop  = instr_valid & instr_ready;
    assign push = inflight_q & ~redirect;

    // A slot freed by this cycle's pop can be reused by the request issued now.
    assign used_credit = occupancy_q + {2'b00, inflight_q} - {2'b00, pop};
    assign imem_req    = rst & ~redirect & (used_credit < DEPTH3);

    always_comb begin
        pc_d        = pc_q;
        issued_pc_d = pc_q;
        inflight_d  = imem_req;
        head_d      = head_q;
        tail_d      = tail_q;
        occupancy_d = occupancy_q;
        if (redirect) begin
            pc_d        = {redirect_pc[31:2], 2'b00};
            head_d      = 2'd0;
            tail_d      = 2'd0;
            occupancy_d = 3'd0;
        end else begin
            if (imem_req) pc_d = pc_q + 32'd4;
            if (pop) head_d = ptr_inc(head_q);
            if (push) tail_d = ptr_inc(tail_q);
            occupancy_d = occupancy_q + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            issued_pc_q <= 32'h0;
            inflight_q  <= 1'b0;
            head_q      <= 2'd0;
            tail_q      <= 2'd0;
            occupancy_q <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                instr_mem_q[i] <= 32'h0;
                pc_mem_q[i]    <= 32'h0;
            end
        end else begin
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            occupancy_q <= occupancy_d;
            if (push) begin
                instr_mem_q[tail_q] <= imem_rdata;
                pc_mem_q[tail_q]    <= issued_pc_q;
            end
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (occupancy_q == DEPTH3)));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, random phase, wrap-around instance.
module tb_instr_fetch;

  localparam logic [31:0] K      = 32'hA5A5_0000;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] W_RST  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  occupancy;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata = 32'h0;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [2:0]  w_occ;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .occupancy(occupancy)
  );

  instr_fetch #(.RESET_PC(W_RST), .BUF_DEPTH(3)) u_dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .redirect(1'b0), .redirect_pc(32'h0),
    .instr(w_instr), .instr_pc(w_pc), .instr_valid(w_valid),
    .instr_ready(w_ready), .occupancy(w_occ)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        mq[$];
  logic        m_inf    = 1'b0;
  logic [31:0] m_inf_pc = 32'h0;
  logic [31:0] m_pc     = 32'h0;
  logic [31:0] pop_log[$];
  logic [31:0] rdata_nxt = 32'h0;

  logic [31:0] w_exp = W_RST;
  logic [31:0] w_seen[$];
  logic [31:0] w_rdata_nxt = 32'h0;

  always @(negedge clk) begin
    logic e_valid;
    logic m_pop;
    logic e_req;
    int   used;
    ent_t e;
    e_valid = rst && (mq.size() != 0);
    m_pop   = e_valid && instr_ready;
    used    = mq.size() + int'(m_inf) - int'(m_pop);
    e_req   = rst && !redirect && (used < DEPTH);

    chk("m_req", imem_req, e_req);
    chk("m_addr", imem_addr, m_pc);
    chk("m_valid", instr_valid, e_valid);
    chk("m_occ", occupancy, mq.size());
    if (e_valid) begin
      chk("m_instr", instr, mq[0].word);
      chk("m_instr_pc", instr_pc, mq[0].pc);
    end
    if (instr_valid && instr_ready) pop_log.push_back(instr_pc);

    if (!rst) begin
      mq.delete();
      m_inf = 1'b0;
      m_pc  = 32'h0;
    end else if (redirect) begin
      mq.delete();
      m_inf = 1'b0;
      m_pc  = {redirect_pc[31:2], 2'b00};
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_inf) begin
        e.pc   = m_inf_pc;
        e.word = m_inf_pc ^ K;
        mq.push_back(e);
      end
      m_inf    = e_req;
      m_inf_pc = m_pc;
      if (e_req) m_pc = m_pc + 32'd4;
    end

    // Memory responds to the DUT's actual request; garbage otherwise.
    rdata_nxt = imem_req ? (imem_addr ^ K) : $urandom;

    // Wrap-around instance: stream must be consecutive from its reset PC.
    if (!rst) begin
      w_exp = W_RST;
      if (w_seen.size() < 4) w_seen.delete();
    end else if (w_valid && w_ready) begin
      chk("w_pc", w_pc, w_exp);
      chk("w_instr", w_instr, w_exp ^ K);
      if (w_seen.size() < 4) w_seen.push_back(w_pc);
      w_exp = w_exp + 32'd4;
    end
    chk("w_occ_bound", {31'h0, (w_occ > 3'd3)}, 32'h0);
    w_rdata_nxt = w_req ? (w_addr ^ K) : $urandom;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      imem_rdata = rdata_nxt;
      w_rdata    = w_rdata_nxt;
      w_ready    = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int marker;
    int n8;
    int n12;
    logic [31:0] w_lit [4];
    w_lit[0] = 32'hFFFF_FFF8;
    w_lit[1] = 32'hFFFF_FFFC;
    w_lit[2] = 32'h0000_0000;
    w_lit[3] = 32'h0000_0004;

    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_addr", imem_addr, 32'h0);

    // Release; consumer stalled from the start.
    tick(); rst = 1'b1; instr_ready = 1'b0;
    @(negedge clk);
    chk("rel_req", imem_req, 1);
    chk("rel_addr", imem_addr, 32'h0);
    chk("rel_valid", instr_valid, 0);
    tick(); @(negedge clk);
    chk("lat1_valid", instr_valid, 0);
    chk("lat1_addr", imem_addr, 32'h4);
    tick(); @(negedge clk);
    chk("lat2_valid", instr_valid, 1);
    chk("lat2_pc", instr_pc, 32'h0);
    chk("lat2_instr", instr, 32'hA5A5_0000);
    repeat (4) begin tick(); @(negedge clk); end
    chk("stall_occ", occupancy, 2);
    chk("stall_req", imem_req, 0);
    chk("stall_pc", instr_pc, 32'h0);
    chk("stall_instr", instr, 32'hA5A5_0000);

    tick(); instr_ready = 1'b1; @(negedge clk);
    chk("go0_pc", instr_pc, 32'h0);
    tick(); @(negedge clk);
    chk("go1_pc", instr_pc, 32'h4);
    tick(); @(negedge clk);
    chk("go2_pc", instr_pc, 32'h8);
    tick(); @(negedge clk);
    chk("go3_pc", instr_pc, 32'hC);
    chk("go3_instr", instr, 32'hA5A5_000C);
    tick(); @(negedge clk);
    chk("go4_pc", instr_pc, 32'h10);
    chk("go4_valid", instr_valid, 1);

    // Fill the buffer, then redirect with a misaligned target.
    tick(); instr_ready = 1'b0; @(negedge clk);
    tick(); @(negedge clk);
    chk("fill_occ", occupancy, 2);
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0103; @(negedge clk);
    chk("rd_req", imem_req, 0);
    tick(); redirect = 1'b0; instr_ready = 1'b1; @(negedge clk);
    chk("rd1_occ", occupancy, 0);
    chk("rd1_valid", instr_valid, 0);
    chk("rd1_req", imem_req, 1);
    chk("rd1_addr", imem_addr, 32'h100);
    tick(); @(negedge clk);
    chk("rd2_valid", instr_valid, 0);
    tick(); @(negedge clk);
    chk("rd3_valid", instr_valid, 1);
    chk("rd3_pc", instr_pc, 32'h100);
    chk("rd3_instr", instr, 32'hA5A5_0100);

    // One-cycle reset while streaming with a response in flight.
    tick(); rst = 1'b0; @(negedge clk);
    chk("mr_req", imem_req, 0);
    chk("mr_valid", instr_valid, 0);
    tick(); rst = 1'b1; marker = pop_log.size(); @(negedge clk);
    chk("mr1_occ", occupancy, 0);
    chk("mr1_valid", instr_valid, 0);
    chk("mr1_addr", imem_addr, 32'h0);
    chk("mr1_req", imem_req, 1);
    tick(); @(negedge clk);
    chk("mr2_valid", instr_valid, 0);
    tick(); @(negedge clk);
    chk("mr3_pc", instr_pc, 32'h0);
    chk("mr3_instr", instr, 32'hA5A5_0000);
    tick(); @(negedge clk);
    chk("mr4_pc", instr_pc, 32'h4);

    // Redirect in the same cycle pc 8 is popped.
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0200; @(negedge clk);
    chk("rp_pc", instr_pc, 32'h8);
    chk("rp_req", imem_req, 0);
    tick(); redirect = 1'b0; @(negedge clk);
    chk("rp1_valid", instr_valid, 0);
    chk("rp1_addr", imem_addr, 32'h200);
    tick(); @(negedge clk);
    chk("rp2_valid", instr_valid, 0);
    tick(); @(negedge clk);
    chk("rp3_valid", instr_valid, 1);
    chk("rp3_pc", instr_pc, 32'h200);
    chk("rp3_instr", instr, 32'hA5A5_0200);
    tick();
    n8 = 0; n12 = 0;
    for (int i = marker; i < pop_log.size(); i++) begin
      if (pop_log[i] == 32'h8) n8++;
      if (pop_log[i] == 32'hC) n12++;
    end
    chk("rp_pop8_once", n8, 1);
    chk("rp_pop12_none", n12, 0);
    chk("rp_last_pop", pop_log[pop_log.size() - 1], 32'h200);

    // Random phase.
    repeat (3000) begin
      tick();
      rst         = ($urandom_range(0, 99) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      instr_ready = ($urandom_range(0, 9) < 7);
    end
    tick(); rst = 1'b1; redirect = 1'b0; instr_ready = 1'b1;
    repeat (5) tick();

    chk("w_seen_len", w_seen.size(), 4);
    for (int i = 0; i < 4 && i < w_seen.size(); i++) chk("w_seen_pc", w_seen[i], w_lit[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
